// File: rtl/mdio_pkg.sv
// MDIO Clause 22 frame constants, field widths and responder states.
package mdio_pkg;

   localparam logic [1:0] MDIO_ST    = 2'b01;
   localparam logic [1:0] MDIO_OP_RD = 2'b10;
   localparam logic [1:0] MDIO_OP_WR = 2'b01;

   localparam int PHYAD_W = 5;
   localparam int REGAD_W = 5;
   localparam int DATA_W  = 16;
   localparam int TA_W    = 2;

   typedef enum logic [2:0] {
      IDLE,
      ST1,
      OP,
      PHYAD,
      REGAD,
      TA,
      DATA
   } mdio_state_e;

endpackage

// File: rtl/mdio_sync_edge.sv
// Two-flop synchronisers for MDC/MDIO, with an MDC rising-edge pulse.
module mdio_sync_edge (
   input  logic aclk,
   input  logic aresetn,
   input  logic mdc_i,
   input  logic mdio_i,
   output logic mdc_rise,
   output logic mdio_s
);

   logic [2:0] mdc_q;
   logic [1:0] mdio_q;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         mdc_q  <= 3'b000;
         mdio_q <= 2'b11;
      end else begin
         mdc_q  <= {mdc_q[1:0], mdc_i};
         mdio_q <= {mdio_q[0], mdio_i};
      end
   end

   assign mdc_rise = mdc_q[1] & ~mdc_q[2];
   assign mdio_s   = mdio_q[1];

endmodule

// File: rtl/mdio_phy_responder.sv
// MDIO Clause 22 PHY-side responder: decodes frames, strobes a register
// bank in the aclk domain and drives read data back to the master.
module mdio_phy_responder
   import mdio_pkg::*;
#(
   parameter logic [PHYAD_W-1:0] PHY_ADDR     = 5'd1,
   parameter int                 PREAMBLE_LEN = 32
) (
   input  logic               aclk,
   input  logic               aresetn,
   input  logic               mdc_i,
   input  logic               mdio_i,
   output logic               mdio_o,
   output logic               mdio_oe,
   output logic [REGAD_W-1:0] reg_addr,
   output logic               reg_ren,
   input  logic [DATA_W-1:0]  reg_rdata,
   output logic               reg_wen,
   output logic [DATA_W-1:0]  reg_wdata,
   output logic               busy
);

   mdio_state_e        state, state_nxt;
   logic [5:0]         pre_cnt, pre_cnt_nxt;
   logic [3:0]         cnt, cnt_nxt;
   logic [4:0]         fld, fld_nxt, fld_in;
   logic               is_rd, is_rd_nxt;
   logic               match, match_nxt;
   logic [DATA_W-1:0]  shreg, shreg_nxt;
   logic [DATA_W-1:0]  wdata_nxt;
   logic [REGAD_W-1:0] addr_nxt;
   logic               ren_nxt, wen_nxt, ren_d;
   logic               o_nxt, oe_nxt;
   logic               rise, din, rd_hit;

   mdio_sync_edge u_sync (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .mdc_i    (mdc_i),
      .mdio_i   (mdio_i),
      .mdc_rise (rise),
      .mdio_s   (din)
   );

   assign fld_in = {fld[3:0], din};
   assign rd_hit = match & is_rd;
   assign busy   = (state != IDLE);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state     <= IDLE;
         pre_cnt   <= '0;
         cnt       <= '0;
         fld       <= '0;
         is_rd     <= 1'b0;
         match     <= 1'b0;
         shreg     <= '0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         reg_ren   <= 1'b0;
         reg_wen   <= 1'b0;
         ren_d     <= 1'b0;
         mdio_o    <= 1'b1;
         mdio_oe   <= 1'b0;
      end else begin
         state     <= state_nxt;
         pre_cnt   <= pre_cnt_nxt;
         cnt       <= cnt_nxt;
         fld       <= fld_nxt;
         is_rd     <= is_rd_nxt;
         match     <= match_nxt;
         shreg     <= shreg_nxt;
         reg_addr  <= addr_nxt;
         reg_wdata <= wdata_nxt;
         reg_ren   <= ren_nxt;
         reg_wen   <= wen_nxt;
         ren_d     <= reg_ren;
         mdio_o    <= o_nxt;
         mdio_oe   <= oe_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      pre_cnt_nxt = pre_cnt;
      cnt_nxt     = cnt;
      fld_nxt     = fld;
      is_rd_nxt   = is_rd;
      match_nxt   = match;
      shreg_nxt   = shreg;
      addr_nxt    = reg_addr;
      wdata_nxt   = reg_wdata;
      ren_nxt     = 1'b0;
      wen_nxt     = 1'b0;
      o_nxt       = mdio_o;
      oe_nxt      = mdio_oe;
      // Bank data arrives the cycle after the strobe
      if (ren_d)
         shreg_nxt = reg_rdata;
      if (rise) begin
         unique case (state)
            IDLE: begin
               if (din) begin
                  if (pre_cnt != 6'd32)
                     pre_cnt_nxt = pre_cnt + 6'd1;
               end else begin
                  pre_cnt_nxt = '0;
                  if (pre_cnt >= 6'(PREAMBLE_LEN))
                     state_nxt = ST1;
               end
            end
            ST1: begin
               if (din == MDIO_ST[0]) begin
                  state_nxt = OP;
                  cnt_nxt   = 4'd1;
               end else begin
                  state_nxt = IDLE;
               end
            end
            OP: begin
               fld_nxt = fld_in;
               if (cnt != 4'd0) begin
                  cnt_nxt = cnt - 4'd1;
               end else if (fld_in[1:0] == MDIO_OP_RD ||
                            fld_in[1:0] == MDIO_OP_WR) begin
                  is_rd_nxt = (fld_in[1:0] == MDIO_OP_RD);
                  state_nxt = PHYAD;
                  cnt_nxt   = 4'(PHYAD_W - 1);
               end else begin
                  state_nxt = IDLE;
               end
            end
            PHYAD: begin
               fld_nxt = fld_in;
               if (cnt != 4'd0) begin
                  cnt_nxt = cnt - 4'd1;
               end else begin
                  match_nxt = (fld_in == PHY_ADDR);
                  state_nxt = REGAD;
                  cnt_nxt   = 4'(REGAD_W - 1);
               end
            end
            REGAD: begin
               fld_nxt = fld_in;
               if (cnt != 4'd0) begin
                  cnt_nxt = cnt - 4'd1;
               end else begin
                  addr_nxt  = fld_in;
                  ren_nxt   = rd_hit;
                  state_nxt = TA;
                  cnt_nxt   = 4'(TA_W - 1);
               end
            end
            TA: begin
               if (cnt != 4'd0) begin
                  cnt_nxt = cnt - 4'd1;
                  if (rd_hit) begin
                     oe_nxt = 1'b1;
                     o_nxt  = 1'b0;
                  end
               end else begin
                  state_nxt = DATA;
                  cnt_nxt   = 4'(DATA_W - 1);
                  if (rd_hit) begin
                     o_nxt     = shreg[DATA_W-1];
                     shreg_nxt = {shreg[DATA_W-2:0], 1'b0};
                  end
               end
            end
            DATA: begin
               if (rd_hit) begin
                  if (cnt != 4'd0) begin
                     o_nxt     = shreg[DATA_W-1];
                     shreg_nxt = {shreg[DATA_W-2:0], 1'b0};
                  end else begin
                     oe_nxt = 1'b0;
                     o_nxt  = 1'b1;
                  end
               end
               if (match && !is_rd)
                  wdata_nxt = {reg_wdata[DATA_W-2:0], din};
               if (cnt != 4'd0) begin
                  cnt_nxt = cnt - 4'd1;
               end else begin
                  wen_nxt     = match & ~is_rd;
                  state_nxt   = IDLE;
                  pre_cnt_nxt = '0;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Scoreboard bench for mdio_phy_responder: a master task drives frames,
// monitors pop expected strobes and read data as the DUT produces them.
module tb_mdio_phy_responder;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        mdc_i = 1'b0;
   logic        mdio_i = 1'b1;
   logic        mdio_o, mdio_oe;
   logic [4:0]  reg_addr;
   logic        reg_ren, reg_wen, busy;
   logic [15:0] reg_rdata = 16'h0;
   logic [15:0] reg_wdata;

   int total = 0;
   int bad = 0;

   logic [15:0] mem [32];
   logic [4:0]  ren_q [$];
   logic [20:0] wen_q [$];
   logic [15:0] rd_q [$];
   logic [16:0] run = '0;
   int          run_cnt = 0;

   localparam logic [1:0] RD = 2'b10;
   localparam logic [1:0] WR = 2'b01;

   mdio_phy_responder #(.PHY_ADDR(5'd1), .PREAMBLE_LEN(32)) dut (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .mdc_i     (mdc_i),
      .mdio_i    (mdio_i),
      .mdio_o    (mdio_o),
      .mdio_oe   (mdio_oe),
      .reg_addr  (reg_addr),
      .reg_ren   (reg_ren),
      .reg_rdata (reg_rdata),
      .reg_wen   (reg_wen),
      .reg_wdata (reg_wdata),
      .busy      (busy)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", name, got, exp);
      end
   endtask

   // register bank behind the responder
   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 16'h0;
      mem[1] = 16'h1234;
      mem[2] = 16'h0141;
   end

   always @(posedge aclk) begin
      if (reg_ren) reg_rdata <= mem[reg_addr];
      if (reg_wen) mem[reg_addr] <= reg_wdata;
   end

   // strobe monitor
   always @(negedge aclk) begin
      if (aresetn) begin
         if (reg_ren) begin
            if (ren_q.size() == 0) chk("ren_spurious", 32'(reg_ren), 0);
            else chk("ren_addr", 32'(reg_addr), 32'(ren_q.pop_front()));
         end
         if (reg_wen) begin
            if (wen_q.size() == 0) chk("wen_spurious", 32'(reg_wen), 0);
            else chk("wen_addr_data", {11'd0, reg_addr, reg_wdata},
                     32'(wen_q.pop_front()));
         end
      end
   end

   // read-data monitor: master samples the line on each MDC rise
   always @(posedge mdc_i) begin
      if (mdio_oe) begin
         run = {run[15:0], mdio_o};
         run_cnt++;
      end
   end

   always @(negedge mdio_oe) begin
      if (aresetn) begin
         if (rd_q.size() == 0) begin
            chk("oe_spurious", 32'(run_cnt), 0);
         end else begin
            chk("rd_oe_periods", 32'(run_cnt), 17);
            chk("rd_ta2_bit", 32'(run[16]), 0);
            chk("rd_data", 32'(run[15:0]), 32'(rd_q.pop_front()));
         end
      end
      run_cnt = 0;
   end

   task automatic mdc_bit(input logic b);
      mdio_i = b;
      repeat (4) @(negedge aclk);
      mdc_i = 1'b1;
      repeat (4) @(negedge aclk);
      mdc_i = 1'b0;
   endtask

   // nbits: number of frame bits after the preamble to send (32 = full)
   task automatic frame(input logic [1:0] op, input logic [4:0] phy,
                        input logic [4:0] ra, input logic [15:0] wd,
                        input int pre, input int nbits);
      logic [31:0] fb;
      if (op == RD) fb = {2'b01, op, phy, ra, 2'b11, 16'hFFFF};
      else          fb = {2'b01, op, phy, ra, 2'b10, wd};
      for (int i = 0; i < pre; i++) mdc_bit(1'b1);
      for (int i = 0; i < nbits; i++) mdc_bit(fb[31-i]);
      mdio_i = 1'b1;
   endtask

   initial begin
      repeat (5) @(negedge aclk);
      chk("rst_oe", 32'(mdio_oe), 0);
      chk("rst_o", 32'(mdio_o), 1);
      chk("rst_ren", 32'(reg_ren), 0);
      chk("rst_wen", 32'(reg_wen), 0);
      chk("rst_addr", 32'(reg_addr), 0);
      chk("rst_wdata", 32'(reg_wdata), 0);
      chk("rst_busy", 32'(busy), 0);
      aresetn = 1'b1;
      repeat (5) @(negedge aclk);

      ren_q.push_back(5'd2); rd_q.push_back(16'h0141);
      frame(RD, 5'd1, 5'd2, 16'h0, 32, 32);
      chk("busy_after_rd", 32'(busy), 0);

      wen_q.push_back({5'd0, 16'h8000});
      frame(WR, 5'd1, 5'd0, 16'h8000, 32, 32);
      chk("busy_after_wr", 32'(busy), 0);

      frame(RD, 5'd3, 5'd2, 16'h0, 32, 32);
      chk("busy_after_nomatch", 32'(busy), 0);
      ren_q.push_back(5'd2); rd_q.push_back(16'h0141);
      frame(RD, 5'd1, 5'd2, 16'h0, 32, 32);

      frame(RD, 5'd1, 5'd2, 16'h0, 31, 32);
      frame(2'b11, 5'd1, 5'd2, 16'hFFFF, 32, 32);
      chk("busy_after_bad_op", 32'(busy), 0);

      ren_q.push_back(5'd1);
      frame(RD, 5'd1, 5'd1, 16'h0, 32, 21);
      chk("mid_busy", 32'(busy), 1);
      chk("mid_oe", 32'(mdio_oe), 1);
      #2 aresetn = 1'b0;
      #1 chk("rst_async_oe", 32'(mdio_oe), 0);
      chk("rst_async_busy", 32'(busy), 0);
      repeat (3) @(negedge aclk);
      aresetn = 1'b1;
      repeat (3) @(negedge aclk);
      ren_q.push_back(5'd1); rd_q.push_back(16'h1234);
      frame(RD, 5'd1, 5'd1, 16'h0, 32, 32);

      wen_q.push_back({5'd4, 16'hA5A5});
      frame(WR, 5'd1, 5'd4, 16'hA5A5, 32, 32);
      frame(RD, 5'd1, 5'd4, 16'h0, 0, 32);
      ren_q.push_back(5'd4); rd_q.push_back(16'hA5A5);
      frame(RD, 5'd1, 5'd4, 16'h0, 32, 32);

      repeat (20) @(negedge aclk);
      chk("ren_q_left", 32'(ren_q.size()), 0);
      chk("wen_q_left", 32'(wen_q.size()), 0);
      chk("rd_q_left", 32'(rd_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
